// File: rtl/encoder_pulse_gen_pkg.sv
// encoder_pkg: constants, types and helpers shared by the encoder pulse
// generator and its companion pulse counter.
//   DIV_DEF / WINDOW_DEF : default divider terminal count and ticks per window
//   RATE_W               : width of a rate / pulse count
//   state_t              : generator state (IDLE, RUN)
//   clog2()              : ceil(log2(v)), used for register widths
package encoder_pkg;

    localparam int DIV_DEF    = 4999;
    localparam int WINDOW_DEF = 30;
    localparam int RATE_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_pulse_gen_if.sv
// encoder_pulse_gen_if: control, rate handshake and pulse outputs of the
// generator.
//   En          : generator enable
//   Rate        : requested pulses per window, with Rate_valid / Rate_ready
//   A           : pulse output, one CLK cycle high per pulse
//   Win_strobe  : one-cycle strobe at the end of each window
//   Pulse_cnt   : pulses emitted so far in the current window
// master drives En/Rate/Rate_valid; slave (the generator) drives the rest.
interface encoder_pulse_gen_if;

    logic                           En;
    logic [encoder_pkg::RATE_W-1:0] Rate;
    logic                           Rate_valid;
    logic                           Rate_ready;
    logic                           A;
    logic                           Win_strobe;
    logic [encoder_pkg::RATE_W-1:0] Pulse_cnt;

    modport master (
        output En, Rate, Rate_valid,
        input  Rate_ready, A, Win_strobe, Pulse_cnt
    );

    modport slave (
        input  En, Rate, Rate_valid,
        output Rate_ready, A, Win_strobe, Pulse_cnt
    );

endinterface

// File: rtl/encoder_pulse_gen_window_timer.sv
// window_timer: window cycle index cyc (0..PERIOD-1) with terminal-count flag.
//   CLK, RST : clock, asynchronous active-low reset
//   run      : count while high; cyc is held at 0 while low
//   tc       : high while cyc == PERIOD-1 (last cycle of the window)
module window_timer #(
    parameter int PERIOD = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic tc
);

    localparam int CW = encoder_pkg::clog2(PERIOD);

    logic [CW-1:0] cyc;

    assign tc = (cyc == CW'(PERIOD - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            cyc <= '0;
        else if (!run || tc) cyc <= '0;
        else                 cyc <= cyc + 1'b1;
    end

endmodule

// File: rtl/encoder_pulse_gen.sv
// encoder_pulse_gen: emits exactly Rate rising edges on A per window of
// PERIOD = (DIV+1)*WINDOW CLK cycles, spread evenly by an accumulator that
// adds the rate every cycle and overflows at PERIOD.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : encoder_pulse_gen_if.slave (En, rate handshake, A,
//              Win_strobe, Pulse_cnt)
// A new rate waits in a one-entry pending slot and is applied only at a
// window boundary or on the IDLE->RUN transition.
module encoder_pulse_gen
    import encoder_pkg::*;
#(
    parameter int DIV    = DIV_DEF,
    parameter int WINDOW = WINDOW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    encoder_pulse_gen_if.slave bus
);

    localparam int PERIOD     = (DIV + 1) * WINDOW;
    localparam int RATE_MAX_I = (PERIOD / 2 < 255) ? PERIOD / 2 : 255;
    localparam int ACC_W      = clog2(PERIOD + 256);

    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(RATE_MAX_I);
    localparam logic [ACC_W-1:0]  PERIOD_A = ACC_W'(PERIOD);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [RATE_W-1:0]   cur_rate_q, cur_rate_d;
    logic [RATE_W-1:0]   pend_rate_q, pend_rate_d;
    logic                pend_full_q, pend_full_d;
    logic                a_q, a_d;
    logic                strobe_q, strobe_d;
    logic [RATE_W-1:0]   cnt_q, cnt_d, cnt_base, rate_clamped;
    logic                run, tc, ovf, xfer, load;

    assign run = (state_q == RUN) && bus.En;

    window_timer #(.PERIOD(PERIOD)) u_timer (
        .CLK (CLK),
        .RST (RST),
        .run (run),
        .tc  (tc)
    );

    assign xfer         = bus.Rate_valid && !pend_full_q;
    assign rate_clamped = (bus.Rate > RATE_MAX) ? RATE_MAX : bus.Rate;
    assign sum          = acc_q + ACC_W'(cur_rate_q);
    assign ovf          = (sum >= PERIOD_A);
    // The final count of a window is shown together with Win_strobe; the
    // count restarts on the following cycle.
    assign cnt_base     = strobe_q ? '0 : cnt_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = '0;
        a_d      = 1'b0;
        strobe_d = 1'b0;
        cnt_d    = '0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.En) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.En) begin
                    state_d = IDLE;           // partial window is dropped
                end else begin
                    a_d   = ovf;
                    acc_d = ovf ? (sum - PERIOD_A) : sum;
                    cnt_d = cnt_base + {{(RATE_W-1){1'b0}}, ovf};
                    if (tc) begin
                        strobe_d = 1'b1;
                        acc_d    = '0;
                        load     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cur_rate_d  = (load && pend_full_q) ? pend_rate_q : cur_rate_q;
        // A consumed slot may be refilled on the same edge.
        pend_full_d = (pend_full_q && !load) || xfer;
        pend_rate_d = xfer ? rate_clamped : pend_rate_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cur_rate_q  <= '0;
            pend_rate_q <= '0;
            pend_full_q <= 1'b0;
            a_q         <= 1'b0;
            strobe_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cur_rate_q  <= cur_rate_d;
            pend_rate_q <= pend_rate_d;
            pend_full_q <= pend_full_d;
            a_q         <= a_d;
            strobe_q    <= strobe_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.A          = a_q;
    assign bus.Win_strobe = strobe_q;
    assign bus.Pulse_cnt  = cnt_q;
    assign bus.Rate_ready = !pend_full_q;

endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Bench for encoder_pulse_gen with DIV=1, WINDOW=10 (PERIOD=20).
// Stimulus pushes the expected per-window pulse pattern and count; a
// negedge monitor rebuilds each window's pattern from A at every Win_strobe
// and compares against the head of the queue.
module tb_encoder_pulse_gen;

    localparam int P = 20;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    encoder_pulse_gen_if bus();

    encoder_pulse_gen #(.DIV(1), .WINDOW(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int           rate;
        logic [P-1:0] mask;   // bit c set: pulse computed at window cycle c
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [P-1:0] M0  = 20'h00000;
    localparam logic [P-1:0] M3  = 20'h82040;  // 6, 13, 19
    localparam logic [P-1:0] M4  = 20'h84210;  // 4, 9, 14, 19
    localparam logic [P-1:0] M5  = 20'h88888;  // 3, 7, 11, 15, 19
    localparam logic [P-1:0] M10 = 20'hAAAAA;  // 1, 3, ..., 19

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, req);
        end
    endtask

    task automatic push(input int r, input logic [P-1:0] m);
        win_t w;
        w.rate = r;
        w.mask = m;
        exp_q.push_back(w);
    endtask

    // ---------------- monitor ----------------
    logic [P-1:0] hist;
    logic         prev_a;

    always @(negedge CLK) begin
        if (!RST) begin
            hist   = '0;
            prev_a = 1'b0;
        end else begin
            hist = {hist[P-2:0], bus.A};
            if (bus.A) check("no_adjacent_high", int'(prev_a), 0);
            prev_a = bus.A;
            if (bus.Win_strobe) begin
                check("strobe_has_expectation", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    win_t         w;
                    logic [P-1:0] obs;
                    w = exp_q.pop_front();
                    for (int c = 0; c < P; c++) obs[c] = hist[P-1-c];
                    check("pulse_mask", int'(obs), int'(w.mask));
                    check("pulse_cnt_at_strobe", int'(bus.Pulse_cnt), w.rate);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int r);
        int n;
        n = 0;
        bus.Rate       = r[7:0];
        bus.Rate_valid = 1'b1;
        while (!bus.Rate_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", int'(bus.Rate_ready), 1);
        tick();
        bus.Rate_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.Win_strobe && n < 200);
        check("strobe_seen", int'(bus.Win_strobe), 1);
    endtask

    initial begin
        int n;
        bus.En         = 1'b0;
        bus.Rate       = '0;
        bus.Rate_valid = 1'b0;
        RST            = 1'b0;
        repeat (3) tick();
        check("rst_A", int'(bus.A), 0);
        check("rst_strobe", int'(bus.Win_strobe), 0);
        check("rst_cnt", int'(bus.Pulse_cnt), 0);
        check("rst_ready", int'(bus.Rate_ready), 1);
        RST = 1'b1;
        tick();

        // rate 4 for two windows, then rate 3 for five
        send(4);
        check("ready_low_pending", int'(bus.Rate_ready), 0);
        push(4, M4);
        push(4, M4);
        bus.En = 1'b1;
        wait_strobe(n);
        send(3);
        repeat (5) push(3, M3);
        wait_strobe(n);
        check("ready_after_boundary", int'(bus.Rate_ready), 1);
        repeat (4) wait_strobe(n);

        // mid-window change: current window stays 3, next is 5
        repeat (10) tick();
        send(5);
        check("ready_low_midwindow", int'(bus.Rate_ready), 0);
        push(5, M5);
        wait_strobe(n);
        check("ready_high_at_boundary", int'(bus.Rate_ready), 1);

        // 200 clamps to PERIOD/2 = 10
        send(200);
        push(10, M10);
        wait_strobe(n);
        wait_strobe(n);

        // En dropped at window cycle 12
        repeat (12) tick();
        bus.En = 1'b0;
        tick();
        check("endrop_A", int'(bus.A), 0);
        check("endrop_cnt", int'(bus.Pulse_cnt), 0);
        check("endrop_strobe", int'(bus.Win_strobe), 0);
        check("endrop_cyc", int'(dut.u_timer.cyc), 0);
        tick();
        check("idle_strobe", int'(bus.Win_strobe), 0);
        push(10, M10);
        bus.En = 1'b1;
        wait_strobe(n);
        check("reenable_latency", n, 21);

        // async reset while A is high; pending 7 must be lost
        send(7);
        check("ready_low_before_rst", int'(bus.Rate_ready), 0);
        n = 0;
        while (!bus.A && n < 10) begin
            tick();
            n++;
        end
        check("A_high_before_rst", int'(bus.A), 1);
        #2 RST = 1'b0;
        #1;
        check("async_rst_A", int'(bus.A), 0);
        check("async_rst_ready", int'(bus.Rate_ready), 1);
        check("async_rst_cnt", int'(bus.Pulse_cnt), 0);
        bus.En = 1'b0;
        tick();
        tick();
        RST    = 1'b1;
        bus.En = 1'b1;

        // rate 0 after reset: no pulses, strobe every 20 cycles
        push(0, M0);
        push(0, M0);
        wait_strobe(n);
        check("first_strobe_latency", n, 21);
        wait_strobe(n);
        check("strobe_period", n, P);

        bus.En = 1'b0;
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
